// File: rtl/systolic_feeder_pkg.sv
// Shared constants and state encoding for the systolic operand feeder.
package systolic_feeder_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int N_DEF          = 4;
  localparam int STREAM_LEN     = 2 * N_DEF - 1;
  localparam int FLUSH_LEN      = N_DEF - 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/systolic_feeder_bank.sv
// NxN element store with one write port and N skewed read lanes.
// Lane i returns the element at skew k = step - i; COL_MAJOR selects mem[k][i] instead of mem[i][k].
module feeder_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int N          = 4,
  parameter bit COL_MAJOR  = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_en_i,
  input  logic [1:0]              wr_row_i,
  input  logic [1:0]              wr_col_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [3:0]              step_i,
  output logic [N*DATA_WIDTH-1:0] rd_o
);

  logic [DATA_WIDTH-1:0] r_mem [N][N];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          r_mem[r][c] <= '0;
        end
      end
    end else if (wr_en_i) begin
      r_mem[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [3:0] w_k;
    logic       w_hit;
    assign w_k   = step_i - 4'(i);
    assign w_hit = (step_i >= 4'(i)) && (w_k < 4'(N));
    // Outside the diagonal band the lane carries zero padding.
    assign rd_o[i*DATA_WIDTH +: DATA_WIDTH] =
        !w_hit    ? '0 :
        COL_MAJOR ? r_mem[w_k[1:0]][i] : r_mem[i][w_k[1:0]];
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand formatter for the 4x4 systolic multiplier: streams A rows and B columns
// diagonally skewed, then flushes and pulses done. All outputs are registered.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   ST_IDLE   | lanes zero, element writes accepted, wait start
//   ST_STREAM | step 0..2N-2, skewed A/B lanes emitted
//   ST_FLUSH  | N-1 zero cycles to drain the array
//   ST_DONE   | one cycle, done pulse, back to idle
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int N          = N_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_en_i,
  input  logic                    wr_sel_i,
  input  logic [1:0]              wr_row_i,
  input  logic [1:0]              wr_col_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    start_i,
  output logic [N*DATA_WIDTH-1:0] left_o,
  output logic [N*DATA_WIDTH-1:0] up_o,
  output logic                    busy_o,
  output logic                    done_o
);

  feeder_state_e r_state, w_next_state;
  logic [3:0] r_step, w_next_step;
  logic [N*DATA_WIDTH-1:0] r_left, r_up, w_left, w_up;
  logic r_busy, r_done;
  logic w_wr_ok;

  // A write that coincides with an accepted start is dropped.
  assign w_wr_ok = wr_en_i && (r_state == ST_IDLE) && !start_i;

  feeder_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N), .COL_MAJOR(1'b0)) u_bank_a (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (w_wr_ok && !wr_sel_i),
    .wr_row_i  (wr_row_i),
    .wr_col_i  (wr_col_i),
    .wr_data_i (wr_data_i),
    .step_i    (r_step),
    .rd_o      (w_left)
  );

  feeder_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N), .COL_MAJOR(1'b1)) u_bank_b (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (w_wr_ok && wr_sel_i),
    .wr_row_i  (wr_row_i),
    .wr_col_i  (wr_col_i),
    .wr_data_i (wr_data_i),
    .step_i    (r_step),
    .rd_o      (w_up)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
    end else begin
      r_state <= w_next_state;
      r_step  <= w_next_step;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_step  = r_step;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_next_state = ST_STREAM;
          w_next_step  = '0;
        end
      end
      ST_STREAM: begin
        if (r_step == 4'(STREAM_LEN - 1)) begin
          w_next_state = ST_FLUSH;
          w_next_step  = '0;
        end else begin
          w_next_step = r_step + 4'd1;
        end
      end
      ST_FLUSH: begin
        if (r_step == 4'(FLUSH_LEN - 1)) begin
          w_next_state = ST_DONE;
          w_next_step  = '0;
        end else begin
          w_next_step = r_step + 4'd1;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
        w_next_step  = '0;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_step  = '0;
      end
    endcase
  end

  // Outputs lag the state by one cycle so lane data and busy/done stay aligned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_left <= '0;
      r_up   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_left <= (r_state == ST_STREAM) ? w_left : '0;
      r_up   <= (r_state == ST_STREAM) ? w_up : '0;
      r_busy <= (r_state == ST_STREAM) || (r_state == ST_FLUSH);
      r_done <= (r_state == ST_DONE);
    end
  end

  assign left_o = r_left;
  assign up_o   = r_up;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: skewed lane contents, flush/done timing,
// write/start gating, back-to-back runs and mid-stream reset.
module tb_systolic_feeder;

  localparam int DW = 32;
  localparam int LW = 4 * DW;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          wr_en_i;
  logic          wr_sel_i;
  logic [1:0]    wr_row_i;
  logic [1:0]    wr_col_i;
  logic [DW-1:0] wr_data_i;
  logic          start_i;
  logic [LW-1:0] left_o;
  logic [LW-1:0] up_o;
  logic          busy_o;
  logic          done_o;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] hist_l [7][4];
  logic [DW-1:0] hist_u [7][4];

  always #5 clk_i = ~clk_i;

  systolic_feeder dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (wr_en_i),
    .wr_sel_i  (wr_sel_i),
    .wr_row_i  (wr_row_i),
    .wr_col_i  (wr_col_i),
    .wr_data_i (wr_data_i),
    .start_i   (start_i),
    .left_o    (left_o),
    .up_o      (up_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  // Lane 0 is the first argument (least significant slice).
  function automatic logic [LW-1:0] p4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic write_elem(input logic sel, input logic [1:0] row, input logic [1:0] col,
                            input logic [DW-1:0] data);
    @(negedge clk_i);
    wr_en_i = 1'b1; wr_sel_i = sel; wr_row_i = row; wr_col_i = col; wr_data_i = data;
    @(posedge clk_i);
    #1 wr_en_i = 1'b0;
  endtask

  // Returns 1 ns after the edge that samples start (edge E0).
  task automatic pulse_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; wr_en_i = 1'b0; wr_sel_i = 1'b0; wr_row_i = '0; wr_col_i = '0;
    wr_data_i = '0; start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checks++; if (left_o !== '0) begin failures++; $display("FAIL reset_left got=%h exp=0", left_o); end
    checks++; if (up_o !== '0) begin failures++; $display("FAIL reset_up got=%h exp=0", up_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_o); end
    @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    checks++; if ({busy_o, done_o} !== 2'b00) begin failures++; $display("FAIL reset_pulse_flags got=%b exp=00", {busy_o, done_o}); end
    #2 rst_ni = 1'b1;
  endtask

  task automatic test_full_run();
    logic [LW-1:0] exp_left [7];
    logic [LW-1:0] exp_up [7];
    logic [LW-1:0] el, eu;
    logic [DW-1:0] acc;
    int exp_c0 [4];
    int exp_c3 [4];
    exp_left = '{p4(1,0,0,0), p4(2,5,0,0), p4(3,6,9,0), p4(4,7,10,13),
                 p4(0,8,11,14), p4(0,0,12,15), p4(0,0,0,16)};
    exp_up   = '{p4(1,0,0,0), p4(1,2,0,0), p4(1,2,3,0), p4(1,2,3,4),
                 p4(0,2,3,4), p4(0,0,3,4), p4(0,0,0,4)};
    exp_c0 = '{10, 20, 30, 40};
    exp_c3 = '{58, 116, 174, 232};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        write_elem(1'b0, 2'(r), 2'(c), 32'(4*r + c + 1));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        write_elem(1'b1, 2'(r), 2'(c), 32'(c + 1));
    pulse_start();
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk_i);
      #2;
      el = (k <= 7) ? exp_left[k-1] : '0;
      eu = (k <= 7) ? exp_up[k-1] : '0;
      checks++; if (left_o !== el) begin failures++; $display("FAIL run_left k=%0d got=%h exp=%h", k, left_o, el); end
      checks++; if (up_o !== eu) begin failures++; $display("FAIL run_up k=%0d got=%h exp=%h", k, up_o, eu); end
      checks++; if (busy_o !== (k <= 10)) begin failures++; $display("FAIL run_busy k=%0d got=%b", k, busy_o); end
      checks++; if (done_o !== (k == 11)) begin failures++; $display("FAIL run_done k=%0d got=%b", k, done_o); end
      if (k <= 7)
        for (int i = 0; i < 4; i++) begin
          hist_l[k-1][i] = left_o[i*DW +: DW];
          hist_u[k-1][i] = up_o[i*DW +: DW];
        end
    end
    // PE(r,c) sees left lane r delayed c cycles and up lane c delayed r cycles.
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 2; rr++) begin
        int r;
        r = (rr == 0) ? 0 : 3;
        acc = '0;
        for (int s = 0; s < 13; s++)
          if (s - c >= 0 && s - c < 7 && s - r >= 0 && s - r < 7)
            acc = acc + hist_l[s-c][r] * hist_u[s-r][c];
        checks++;
        if (acc !== 32'((rr == 0) ? exp_c0[c] : exp_c3[c])) begin
          failures++;
          $display("FAIL array_c r=%0d c=%0d got=%0d exp=%0d", r, c, acc,
                   (rr == 0) ? exp_c0[c] : exp_c3[c]);
        end
      end
    end
  endtask

  task automatic test_write_busy();
    int done_cnt, done_at, busy_cnt;
    done_cnt = 0; done_at = 0; busy_cnt = 0;
    pulse_start();
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk_i);
      #2;
      if (done_o) begin done_cnt++; done_at = k; end
      if (busy_o) busy_cnt++;
      if (k == 1) begin
        wr_en_i = 1'b1; wr_sel_i = 1'b0; wr_row_i = 2'd0; wr_col_i = 2'd0; wr_data_i = 32'd99;
      end
      if (k == 2) begin wr_en_i = 1'b0; start_i = 1'b1; end
      if (k == 3) start_i = 1'b0;
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL busy_start_done_count got=%0d exp=1", done_cnt); end
    checks++; if (done_at != 11) begin failures++; $display("FAIL busy_start_done_cycle got=%0d exp=11", done_at); end
    checks++; if (busy_cnt != 10) begin failures++; $display("FAIL busy_cycles got=%0d exp=10", busy_cnt); end
    pulse_start();
    @(posedge clk_i);
    #2;
    checks++; if (left_o !== p4(1,0,0,0)) begin failures++; $display("FAIL busy_write_dropped got=%h exp=%h", left_o, p4(1,0,0,0)); end
    repeat (12) @(posedge clk_i);
  endtask

  task automatic test_same_cycle_write_start();
    int done_cnt;
    done_cnt = 0;
    @(negedge clk_i);
    wr_en_i = 1'b1; wr_sel_i = 1'b0; wr_row_i = 2'd0; wr_col_i = 2'd0; wr_data_i = 32'd77;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 begin wr_en_i = 1'b0; start_i = 1'b0; end
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk_i);
      #2;
      if (done_o) done_cnt++;
      if (k == 1) begin
        checks++; if (left_o !== p4(1,0,0,0)) begin failures++; $display("FAIL start_write_dropped got=%h exp=%h", left_o, p4(1,0,0,0)); end
        checks++; if (up_o !== p4(1,0,0,0)) begin failures++; $display("FAIL start_write_up got=%h exp=%h", up_o, p4(1,0,0,0)); end
      end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL start_write_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    for (int k = 1; k <= 23; k++) begin
      @(posedge clk_i);
      #2;
      if (k == 11) begin
        checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL b2b_done1 got=%b exp=1", done_o); end
      end
      if (k == 12) begin
        checks++; if ({busy_o, done_o} !== 2'b00) begin failures++; $display("FAIL b2b_gap got=%b exp=00", {busy_o, done_o}); end
      end
      if (k == 13) begin
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL b2b_restart_busy got=%b exp=1", busy_o); end
        checks++; if (left_o !== p4(1,0,0,0)) begin failures++; $display("FAIL b2b_restart_left got=%h exp=%h", left_o, p4(1,0,0,0)); end
      end
      if (k == 23) begin
        checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL b2b_done2 got=%b exp=1", done_o); end
        start_i = 1'b0;
      end
    end
    repeat (3) @(posedge clk_i);
  endtask

  task automatic test_reset_mid();
    int done_cnt, busy_cnt, nz_cnt, done_at;
    done_cnt = 0; busy_cnt = 0; nz_cnt = 0; done_at = 0;
    pulse_start();
    repeat (4) @(posedge clk_i);
    #2;
    checks++; if (left_o !== p4(4,7,10,13)) begin failures++; $display("FAIL mid_pre_left got=%h exp=%h", left_o, p4(4,7,10,13)); end
    #1 rst_ni = 1'b0;
    #1;
    checks++; if (left_o !== '0) begin failures++; $display("FAIL mid_reset_left got=%h exp=0", left_o); end
    checks++; if (up_o !== '0) begin failures++; $display("FAIL mid_reset_up got=%h exp=0", up_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", busy_o); end
    #2 rst_ni = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk_i);
      #2;
      if (done_o) done_cnt++;
      if (busy_o) busy_cnt++;
    end
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", done_cnt); end
    checks++; if (busy_cnt != 0) begin failures++; $display("FAIL mid_no_busy got=%0d exp=0", busy_cnt); end
    busy_cnt = 0;
    pulse_start();
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk_i);
      #2;
      if (busy_o) busy_cnt++;
      if (done_o) begin done_cnt++; done_at = k; end
      if (left_o !== '0 || up_o !== '0) nz_cnt++;
    end
    checks++; if (nz_cnt != 0) begin failures++; $display("FAIL cleared_lanes nonzero_cycles got=%0d exp=0", nz_cnt); end
    checks++; if (busy_cnt != 10) begin failures++; $display("FAIL cleared_busy got=%0d exp=10", busy_cnt); end
    checks++; if (done_at != 11 || done_cnt != 1) begin failures++; $display("FAIL cleared_done at=%0d cnt=%0d exp at=11 cnt=1", done_at, done_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_write_busy();
    test_same_cycle_write_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit-side formatter for the 4x4 systolic multiplier. It produces the diagonally skewed operand streams that drive the array's left and up inputs.
- Matrices A and B are written element-by-element through a write port while idle.
- On start, row r of A and column c of B are streamed onto their lanes, delayed by r and c cycles respectively, with zero padding. Flush cycles follow, then a done pulse.
- Sits between the host/memory side and the systolic array.

Parameters:
- DATA_WIDTH, 32, width of every matrix element and lane.
- N, 4, array dimension; fixed at 4 for this release, and lanes are flattened as N*DATA_WIDTH.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- wr_en_i  in  1  element write strobe.
- wr_sel_i  in  1  write target: 0 = A, 1 = B.
- wr_row_i  in  2  element row index.
- wr_col_i  in  2  element column index.
- wr_data_i  in  DATA_WIDTH  element value.
- start_i  in  1  begin streaming; sampled only in IDLE.
- left_o  out  N*DATA_WIDTH  lane r = bits [r*DATA_WIDTH +: DATA_WIDTH], drives left input of array row r.
- up_o  out  N*DATA_WIDTH  lane c, drives up input of array column c.
- busy_o  out  1  high in STREAM and FLUSH.
- done_o  out  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset (async, rst_ni=0):
  - state = IDLE, step counter = 0.
  - left_o = 0, up_o = 0, busy_o = 0, done_o = 0.
  - All A/B storage cleared to 0.
- Writes:
  - Accepted only in IDLE with start_i low: A[row][col] or B[row][col] <= wr_data_i at the edge.
  - A write coinciding with an accepted start, or arriving in any other state, is dropped with no error.
  - Rewriting an element overwrites it; contents persist across runs.
- State IDLE:
  - Outputs are 0.
  - start_i=1 -> STREAM, step t = 0.
- State STREAM (t = 0 .. 2N-2, i.e. 7 cycles for N=4):
  - Lane values are registered. The values for step t appear on the cycle following the edge that entered t (first data one cycle after start is sampled).
  - left lane r = A[r][t-r] if 0 <= t-r <= N-1, else 0.
  - up lane c = B[t-c][c] if 0 <= t-c <= N-1, else 0.
  - At t = 2N-2 -> FLUSH.
- State FLUSH (N-1 = 3 cycles):
  - All lanes 0, busy_o = 1.
  - Lets the last partial products propagate to PE(N-1,N-1).
  - After the last flush cycle -> DONE.
- State DONE (1 cycle):
  - done_o = 1, busy_o = 0, lanes 0.
  - Then -> IDLE.
- Timing:
  - Start-to-done latency = 3N-2 busy cycles + 1; done is high on the 11th cycle after start is sampled for N=4.
  - start_i is ignored outside IDLE; no queuing.
  - start_i held high continuously restarts a new run on the cycle after DONE.
- Reset mid-operation: immediate return to IDLE, outputs 0, storage cleared, no done pulse.
- Arithmetic: none; data passes unmodified at DATA_WIDTH, indices are 2-bit, and the step counter is 4-bit saturating to the state bounds.

Decomposition:
- Shared package:
  - Default DATA_WIDTH and N constants.
  - State encoding IDLE/STREAM/FLUSH/DONE.
  - STREAM_LEN = 2N-1 and FLUSH_LEN = N-1 constants.
- One natural sub-module, feeder_bank: an NxN register file with a write port and N combinational skewed-read ports indexed by step t and an orientation flag (row-major for A, column-major for B). It is instantiated twice; the top holds the FSM and output registers.

Test Plan:
- Reset then idle: rst_ni low for 3 ns mid-clock -> all outputs 0 immediately; busy_o = 0, done_o = 0.
- Full run: load A = 1..16 row-major and B[k][c] = c+1, then pulse start.
  - Stream cycle 0: left = {1,0,0,0}, up = {1,0,0,0}.
  - Stream cycle 3: left = {4,7,10,13}, up = {1,2,3,4}.
  - Stream cycle 6: left = {0,0,0,16}, up = {0,0,0,4}.
  - Then 3 zero cycles, then done_o high for exactly 1 cycle.
- Integration: feeder driving the systolic multiplier with the full-run data -> array output C[r][c] = 10*(c+1)*(4r+2.5)·(2/5)... i.e. row sums of A times c+1: C[0][*] = {10,20,30,40} and C[3][*] = {58,116,174,232}.
- Write during busy: wr_en_i = 1 writing A[0][0] = 99 in STREAM -> ignored; the next run still emits left lane0 = 1 at step 0.
- Start while busy plus same-cycle write/start: start_i pulsed at stream step 2 -> no restart, single done. wr_en_i with start_i in IDLE -> write dropped.
- Reset mid-stream at step 4 -> outputs 0 at once, no done_o. A subsequent start with no reload streams all zeros and done follows after 10 busy cycles.
